// File: rtl/x2050_brkctl_pkg.sv
// Shared definitions for the channel break-in controller: state encoding,
// default timeout and the two-channel round-robin pick.
package x2050pkg;

  localparam int NCH         = 2;
  localparam int CNT_W       = 8;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SUSPEND  = 2'd1,
    ST_CHAN     = 2'd2,
    ST_BREAKOUT = 2'd3
  } brk_state_e;

  // last_ch1 = 1 means channel 1 owned the datapath most recently.
  function automatic logic [NCH-1:0] rr_pick(input logic [NCH-1:0] req,
                                             input logic            last_ch1);
    logic [NCH-1:0] g;
    g = '0;
    if (req == 2'b11)  g = last_ch1 ? 2'b01 : 2'b10;
    else if (req[0])   g = 2'b01;
    else if (req[1])   g = 2'b10;
    return g;
  endfunction

endpackage

// File: rtl/x2050_brkctl.sv
// Selector-channel break-in controller: suspends the CPU microprogram, hands
// the datapath to one channel, then reloads R from local storage on break-out.
module x2050_brkctl
  import x2050pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  input  logic           i_ros_tick,
  input  logic [NCH-1:0] i_chan_req,
  input  logic           i_inhibit,
  input  logic           i_chan_done,
  output logic           o_ros_advance,
  output logic           o_break_out,
  output logic [NCH-1:0] o_grant,
  output logic           o_cpu_hold,
  output logic           o_chan_err
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  brk_state_e       r_state;
  brk_state_e       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [NCH-1:0]   r_grant;
  logic             r_last_ch1;
  logic             r_err;

  logic             w_adv;
  logic             w_brk;
  logic             w_hold;
  logic             w_latch;
  logic             w_timeout;
  logic [NCH-1:0]   w_pick;

  assign w_pick = rr_pick(i_chan_req, r_last_ch1);

  always_comb begin
    w_next    = r_state;
    w_adv     = 1'b0;
    w_brk     = 1'b0;
    w_hold    = 1'b0;
    w_latch   = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_adv = i_ros_tick;
        if (i_ros_tick && (|i_chan_req) && !i_inhibit) begin
          w_next  = ST_SUSPEND;
          w_latch = 1'b1;
        end
      end
      // R stays frozen here so the CPU return point is preserved.
      ST_SUSPEND: begin
        w_hold = 1'b1;
        if (i_ros_tick) w_next = ST_CHAN;
      end
      ST_CHAN: begin
        w_hold    = 1'b1;
        w_adv     = i_ros_tick;
        w_timeout = i_ros_tick && (r_cnt == TO_LAST);
        if (i_ros_tick && (i_chan_done || w_timeout)) w_next = ST_BREAKOUT;
      end
      ST_BREAKOUT: begin
        w_brk = 1'b1;
        w_adv = i_ros_tick;
        if (i_ros_tick) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_grant    <= '0;
      r_last_ch1 <= 1'b1;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_latch) begin
        r_grant    <= w_pick;
        r_last_ch1 <= w_pick[1];
      end else if (i_ros_tick && r_state == ST_BREAKOUT) begin
        r_grant <= '0;
      end
      if (i_ros_tick && r_state == ST_SUSPEND)   r_cnt <= '0;
      else if (i_ros_tick && r_state == ST_CHAN) r_cnt <= r_cnt + 1'b1;
      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign o_ros_advance = w_adv;
  assign o_break_out   = w_brk;
  assign o_cpu_hold    = w_hold;
  assign o_grant       = r_grant;
  assign o_chan_err    = r_err;

endmodule

// File: tb/tb_x2050_brkctl.sv
// Directed bench for the break-in controller, built with TIMEOUT=4.
module tb_x2050_brkctl;

  logic       i_clk = 1'b0;
  logic       i_reset_n;
  logic       i_ros_tick;
  logic [1:0] i_chan_req;
  logic       i_inhibit;
  logic       i_chan_done;
  logic       o_ros_advance;
  logic       o_break_out;
  logic [1:0] o_grant;
  logic       o_cpu_hold;
  logic       o_chan_err;

  int checks   = 0;
  int failures = 0;

  x2050_brkctl #(.TIMEOUT(4)) dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_ros_tick    (i_ros_tick),
    .i_chan_req    (i_chan_req),
    .i_inhibit     (i_inhibit),
    .i_chan_done   (i_chan_done),
    .o_ros_advance (o_ros_advance),
    .o_break_out   (o_break_out),
    .o_grant       (o_grant),
    .o_cpu_hold    (o_cpu_hold),
    .o_chan_err    (o_chan_err)
  );

  always #5 i_clk = ~i_clk;

  // Expected vector order: {adv, break_out, grant[1:0], cpu_hold, chan_err}
  task automatic chk(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    #1;
    obs = {o_ros_advance, o_break_out, o_grant, o_cpu_hold, o_chan_err};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Check this microcycle's outputs, then take one clock edge.
  task automatic step(input string tag, input logic [5:0] exp);
    chk(tag, exp);
    @(posedge i_clk); #1;
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    @(posedge i_clk); #1;
    i_reset_n = 1'b1;
  endtask

  initial begin
    i_reset_n = 1'b0; i_ros_tick = 1'b0; i_chan_req = 2'b00;
    i_inhibit = 1'b0; i_chan_done = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    step("rst", 6'b0_0_00_0_0);

    // Single request from channel 0, done on the second CHAN microcycle;
    // request withdrawn during SUSPEND still completes.
    i_chan_req = 2'b01; i_ros_tick = 1'b1;
    step("t1_idle", 6'b1_0_00_0_0);
    i_chan_req = 2'b00;
    step("t1_susp", 6'b0_0_01_1_0);
    step("t1_chan", 6'b1_0_01_1_0);
    i_chan_done = 1'b1;
    step("t1_chan_done", 6'b1_0_01_1_0);
    i_chan_done = 1'b0;
    step("t1_brk", 6'b1_1_01_0_0);
    step("t1_idle2", 6'b1_0_00_0_0);

    // Both channels requesting: ch0 first after reset, then ch1, IDLE between.
    do_reset();
    i_chan_req = 2'b11;
    step("t2_idle", 6'b1_0_00_0_0);
    step("t2_susp1", 6'b0_0_01_1_0);
    i_chan_done = 1'b1;
    step("t2_chan1", 6'b1_0_01_1_0);
    i_chan_done = 1'b0;
    step("t2_brk1", 6'b1_1_01_0_0);
    step("t2_gap", 6'b1_0_00_0_0);
    step("t2_susp2", 6'b0_0_10_1_0);
    i_chan_done = 1'b1;
    step("t2_chan2", 6'b1_0_10_1_0);
    i_chan_done = 1'b0; i_chan_req = 2'b00;
    step("t2_brk2", 6'b1_1_10_0_0);
    step("t2_idle3", 6'b1_0_00_0_0);

    // Inhibit keeps the CPU running; release lets ch1 in on the next tick.
    i_chan_req = 2'b10; i_inhibit = 1'b1;
    repeat (3) step("t3_inhibit", 6'b1_0_00_0_0);
    i_ros_tick = 1'b0;
    step("t3_notick", 6'b0_0_00_0_0);
    i_ros_tick = 1'b1; i_inhibit = 1'b0;
    step("t3_release", 6'b1_0_00_0_0);
    i_chan_req = 2'b00;
    step("t3_susp", 6'b0_0_10_1_0);
    i_chan_done = 1'b1;
    step("t3_chan", 6'b1_0_10_1_0);
    i_chan_done = 1'b0;
    step("t3_brk", 6'b1_1_10_0_0);

    // Timeout after 4 CHAN ticks, with a 10-cycle tick stall in the middle.
    i_chan_req = 2'b01;
    step("t4_idle", 6'b1_0_00_0_0);
    i_chan_req = 2'b00;
    step("t4_susp", 6'b0_0_01_1_0);
    i_ros_tick = 1'b0;
    repeat (10) step("t4_stall", 6'b0_0_01_1_0);
    i_ros_tick = 1'b1;
    repeat (3) step("t4_chan", 6'b1_0_01_1_0);
    step("t4_chan_last", 6'b1_0_01_1_0);
    step("t4_brk_to", 6'b1_1_01_0_1);
    step("t4_idle_err", 6'b1_0_00_0_1);

    // Done coinciding with timeout: one BREAKOUT only, error stays set.
    i_chan_req = 2'b10;
    step("t4b_idle", 6'b1_0_00_0_1);
    i_chan_req = 2'b00;
    step("t4b_susp", 6'b0_0_10_1_1);
    repeat (3) step("t4b_chan", 6'b1_0_10_1_1);
    i_chan_done = 1'b1;
    step("t4b_chan_both", 6'b1_0_10_1_1);
    i_chan_done = 1'b0;
    step("t4b_brk", 6'b1_1_10_0_1);
    step("t4b_idle2", 6'b1_0_00_0_1);

    // Reset during CHAN aborts immediately, wins over tick and done.
    i_chan_req = 2'b01;
    step("t5_idle", 6'b1_0_00_0_1);
    i_chan_req = 2'b00;
    step("t5_susp", 6'b0_0_01_1_1);
    step("t5_chan", 6'b1_0_01_1_1);
    i_reset_n = 1'b0; i_chan_done = 1'b1;
    step("t5_chan_pre_rst", 6'b1_0_01_1_1);
    chk("t5_in_rst", 6'b1_0_00_0_0);
    i_reset_n = 1'b1; i_chan_done = 1'b0;
    @(posedge i_clk); #1;
    step("t5_post1", 6'b1_0_00_0_0);
    step("t5_post2", 6'b1_0_00_0_0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

endmodule

// File: doc/x2050_brkctl.md
X2050_BRKCTL -- requirements
Module: x2050brkctl

Interface
REQ-001 SHALL have port i_clk, input, 1, sole clock; all state changes on rising edge.
REQ-002 SHALL have port i_reset_n, input, 1, synchronous active-low reset.
REQ-003 SHALL have port i_ros_tick, input, 1, microcycle strobe; at most one state advance per strobe.
REQ-004 SHALL have port i_chan_req, input, 2, break-in request per selector channel; level, held until granted.
REQ-005 SHALL have port i_inhibit, input, 1, CPU microword forbids break-in this microcycle.
REQ-006 SHALL have port i_chan_done, input, 1, channel micro-routine finished; sampled on i_ros_tick.
REQ-007 SHALL have port o_ros_advance, output, 1, advance enable for ROS-clocked registers (R register included).
REQ-008 SHALL have port o_break_out, output, 1, R register reload from local storage this microcycle.
REQ-009 SHALL have port o_grant, output, 2, one-hot channel currently owning the datapath.
REQ-010 SHALL have port o_cpu_hold, output, 1, CPU microprogram suspended.
REQ-011 SHALL have port o_chan_err, output, 1, sticky break-in timeout flag.
REQ-012 SHALL have parameter TIMEOUT, default 255, maximum CHAN microcycles before forced break-out.

Function
REQ-013 SHALL implement states IDLE, SUSPEND, CHAN, BREAKOUT; state changes only on i_ros_tick.
REQ-014 In IDLE: o_ros_advance = i_ros_tick, o_grant = 0, o_cpu_hold = 0, o_break_out = 0.
REQ-015 IDLE->SUSPEND on tick with |i_chan_req and !i_inhibit; grant latched on that tick.
REQ-016 Arbitration: one request wins outright; both requesting -> channel not granted last (round-robin); after reset, channel 0 wins first.
REQ-017 SUSPEND: one microcycle, o_cpu_hold = 1, o_ros_advance = 0 (CPU R frozen, return state held); -> CHAN on next tick.
REQ-018 CHAN: o_cpu_hold = 1, o_ros_advance = i_ros_tick; 8-bit tick counter cleared on CHAN entry, +1 per tick.
REQ-019 CHAN->BREAKOUT on tick with i_chan_done, or on tick where counter = TIMEOUT-1 (timeout also sets o_chan_err).
REQ-020 BREAKOUT: o_break_out = 1 and o_ros_advance = i_ros_tick for exactly one microcycle; -> IDLE on that tick; o_grant cleared on exit.
REQ-021 o_grant SHALL stay constant from SUSPEND entry to BREAKOUT exit; request changes in that span ignored.
REQ-022 i_chan_done and timeout on the same tick: one BREAKOUT; o_chan_err still set.
REQ-023 Request withdrawn during SUSPEND/CHAN: sequence still completes via BREAKOUT.
REQ-024 Back-to-back: request pending on BREAKOUT exit tick SHALL NOT be granted before one IDLE microcycle (CPU executes >= 1 microword).
REQ-025 o_chan_err cleared only by reset.
REQ-026 Without i_ros_tick no state, counter or grant change; outputs other than o_ros_advance hold.

Reset
REQ-027 i_reset_n low at clock edge: state IDLE, counter 0, o_grant 0, last-grant pointer to channel 1 (so channel 0 wins next), o_chan_err 0, o_cpu_hold 0, o_break_out 0.
REQ-028 Reset mid-sequence SHALL abort at once without a BREAKOUT cycle; priority over i_ros_tick.

Structure
REQ-029 State encodings and TIMEOUT default SHALL be in shared package x2050pkg.
REQ-030 Single module; arbiter inline, no sub-module; outputs decoded from state register.

Verification
REQ-031 Reset, then i_chan_req=01 at tick 1 -> SUSPEND tick 2, CHAN tick 3, o_grant=01, o_cpu_hold=1 ticks 2-4; i_chan_done at tick 4 -> o_break_out=1 tick 5, IDLE tick 6.
REQ-032 i_chan_req=11 held over two sequences -> grants 01 then 10; IDLE microcycle between.
REQ-033 i_inhibit=1 with i_chan_req=10 for 3 ticks -> stays IDLE, o_ros_advance follows tick; inhibit drop -> SUSPEND next tick.
REQ-034 Grant, no i_chan_done, TIMEOUT=4 -> BREAKOUT after 4th CHAN tick, o_chan_err=1 persists through later sequences.
REQ-035 Reset low during CHAN -> next edge IDLE, o_grant=0, o_break_out never asserted.
REQ-036 i_ros_tick low for 10 cycles in CHAN -> counter, state, grant unchanged; o_ros_advance=0.
